// File: rtl/ks10_bus_arbiter.sv
// KS10 backplane arbiter: fixed-priority (CON > UBA > CPU) single-owner bus sequencer.
// Optional non-existent-memory timeout is compiled in with `define ARB_TIMEOUT_EN.
module ks10_bus_arbiter #(
   parameter int NXMCNT = 31,
   parameter int CNTW   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpuREQ,
   input  logic [0:35] cpuADDR,
   input  logic [0:35] cpuDATAI,
   output logic        cpuACK,
   input  logic        conREQ,
   input  logic [0:35] conADDR,
   input  logic [0:35] conDATAI,
   output logic        conACK,
   input  logic        ubaREQ,
   input  logic [0:35] ubaADDR,
   input  logic [0:35] ubaDATAI,
   output logic        ubaACK,
   output logic [0:35] rdDATA,
   output logic        memREQ,
   input  logic        memACK,
   input  logic [0:35] memDATAI,
   output logic [0:35] arbADDRO,
   output logic [0:35] arbDATAO,
   output logic [2:0]  arbGNT,
   output logic        nxmERR
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Requester index doubles as the arbGNT bit: 0 = CPU, 1 = UBA, 2 = CON.
   localparam int NREQ = 3;

   if ((1 << CNTW) <= NXMCNT) begin : g_cntw_too_small
      $error("CNTW too narrow to count to NXMCNT");
   end

   state_t            r_state;
   state_t            w_state_next;
   logic [NREQ-1:0]   w_req;
   logic [NREQ-1:0]   w_win;
   logic [NREQ:1]     w_blk;
   logic              w_any;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   w_gnt_next;
   logic [NREQ-1:0]   r_ack;
   logic [NREQ-1:0]   w_ack_next;
   logic              r_memreq;
   logic              w_memreq_next;
   logic [0:35]       r_addr;
   logic [0:35]       w_addr_next;
   logic [0:35]       r_data;
   logic [0:35]       w_data_next;
   logic [0:35]       r_rd;
   logic [0:35]       w_rd_next;
   logic [0:35]       w_addr_arr [NREQ];
   logic [0:35]       w_data_arr [NREQ];
   logic [0:35]       w_addr_acc [NREQ+1];
   logic [0:35]       w_data_acc [NREQ+1];

`ifdef ARB_TIMEOUT_EN
   logic [CNTW-1:0]   r_cnt;
   logic [CNTW-1:0]   w_cnt_next;
   logic [CNTW-1:0]   w_cnt_inc;
   logic              r_nxm_pend;
   logic              w_nxm_pend_next;
   logic              r_nxm;
   logic              w_nxm_next;
`endif

   assign w_req         = {conREQ, ubaREQ, cpuREQ};
   assign w_addr_arr[0] = cpuADDR;
   assign w_addr_arr[1] = ubaADDR;
   assign w_addr_arr[2] = conADDR;
   assign w_data_arr[0] = cpuDATAI;
   assign w_data_arr[1] = ubaDATAI;
   assign w_data_arr[2] = conDATAI;

   // w_blk[i] is set when requester i or anyone above it is asking.
   assign w_blk[NREQ] = 1'b0;
   genvar gi;
   generate
      for (gi = 1; gi < NREQ; gi++) begin : g_blk
         assign w_blk[gi] = w_blk[gi+1] | w_req[gi];
      end
      for (gi = 0; gi < NREQ; gi++) begin : g_win
         assign w_win[gi] = w_req[gi] & ~w_blk[gi+1];
      end
   endgenerate

   assign w_any = |w_req;

   // One-hot AND-OR mux of the winner's address/data.
   assign w_addr_acc[0] = '0;
   assign w_data_acc[0] = '0;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_mux
         assign w_addr_acc[gi+1] = w_addr_acc[gi] | ({36{w_win[gi]}} & w_addr_arr[gi]);
         assign w_data_acc[gi+1] = w_data_acc[gi] | ({36{w_win[gi]}} & w_data_arr[gi]);
      end
   endgenerate

`ifdef ARB_TIMEOUT_EN
   assign w_cnt_inc = r_cnt + 1'b1;
`endif

   always_comb begin
      w_state_next  = r_state;
      w_gnt_next    = r_gnt;
      w_ack_next    = '0;
      w_memreq_next = r_memreq;
      w_addr_next   = r_addr;
      w_data_next   = r_data;
      w_rd_next     = r_rd;
`ifdef ARB_TIMEOUT_EN
      w_cnt_next      = r_cnt;
      w_nxm_pend_next = r_nxm_pend;
      w_nxm_next      = 1'b0;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_gnt_next   = w_win;
               w_addr_next  = w_addr_acc[NREQ];
               w_data_next  = w_data_acc[NREQ];
               w_state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            w_memreq_next = 1'b1;
            w_state_next  = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
            w_cnt_next      = '0;
            w_nxm_pend_next = 1'b0;
`endif
         end
         ST_WAIT: begin
            if (memACK) begin
               w_rd_next     = memDATAI;
               w_memreq_next = 1'b0;
               w_state_next  = ST_DONE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (w_cnt_inc == CNTW'(NXMCNT)) begin
               // Nobody answered: finish with zero data and flag it.
               w_rd_next       = '0;
               w_memreq_next   = 1'b0;
               w_nxm_pend_next = 1'b1;
               w_state_next    = ST_DONE;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
`endif
         end
         ST_DONE: begin
            w_ack_next   = r_gnt;
            w_gnt_next   = '0;
            w_state_next = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            w_nxm_next      = r_nxm_pend;
            w_nxm_pend_next = 1'b0;
`endif
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_ack    <= '0;
         r_memreq <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_rd     <= '0;
`ifdef ARB_TIMEOUT_EN
         r_cnt      <= '0;
         r_nxm_pend <= 1'b0;
         r_nxm      <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_next;
         r_gnt    <= w_gnt_next;
         r_ack    <= w_ack_next;
         r_memreq <= w_memreq_next;
         r_addr   <= w_addr_next;
         r_data   <= w_data_next;
         r_rd     <= w_rd_next;
`ifdef ARB_TIMEOUT_EN
         r_cnt      <= w_cnt_next;
         r_nxm_pend <= w_nxm_pend_next;
         r_nxm      <= w_nxm_next;
`endif
      end
   end

   assign cpuACK   = r_ack[0];
   assign ubaACK   = r_ack[1];
   assign conACK   = r_ack[2];
   assign arbGNT   = r_gnt;
   assign memREQ   = r_memreq;
   assign arbADDRO = r_addr;
   assign arbDATAO = r_data;
   assign rdDATA   = r_rd;
`ifdef ARB_TIMEOUT_EN
   assign nxmERR   = r_nxm;
`else
   assign nxmERR   = 1'b0;
`endif

endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// Directed bench for ks10_bus_arbiter; timeout cases run when ARB_TIMEOUT_EN is defined.
module tb_ks10_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpuREQ, conREQ, ubaREQ;
   logic [0:35] cpuADDR, cpuDATAI, conADDR, conDATAI, ubaADDR, ubaDATAI;
   logic        cpuACK, conACK, ubaACK;
   logic [0:35] rdDATA, memDATAI, arbADDRO, arbDATAO;
   logic        memREQ, memACK, nxmERR;
   logic [2:0]  arbGNT;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [35:0] prev_rd  = '0;

   always #5 clk = ~clk;

   ks10_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .cpuREQ(cpuREQ), .cpuADDR(cpuADDR), .cpuDATAI(cpuDATAI), .cpuACK(cpuACK),
      .conREQ(conREQ), .conADDR(conADDR), .conDATAI(conDATAI), .conACK(conACK),
      .ubaREQ(ubaREQ), .ubaADDR(ubaADDR), .ubaDATAI(ubaDATAI), .ubaACK(ubaACK),
      .rdDATA(rdDATA), .memREQ(memREQ), .memACK(memACK), .memDATAI(memDATAI),
      .arbADDRO(arbADDRO), .arbDATAO(arbDATAO), .arbGNT(arbGNT), .nxmERR(nxmERR)
   );

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %o expected %o", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] acks();
      return {33'd0, conACK, ubaACK, cpuACK};
   endfunction

   // Entered at the negedge right after the IDLE edge that granted g.
   task automatic do_txn(input string tag, input logic [2:0] g, input int delay,
                         input bit ack_en, input logic [35:0] a, input logic [35:0] d,
                         input logic [35:0] rd, input bit stray);
      logic [35:0] exp_rd;
      bit          exp_nxm;
      exp_rd  = ack_en ? rd : 36'd0;
      exp_nxm = !ack_en;
      chk({tag, ".gnt"}, {33'd0, arbGNT}, {33'd0, g});
      chk({tag, ".addr"}, arbADDRO, a);
      chk({tag, ".data"}, arbDATAO, d);
      chk({tag, ".memreq_grant"}, {35'd0, memREQ}, 36'd0);
      if (stray) begin
         memACK   = 1'b1;
         memDATAI = 36'o555555555555;
      end
      @(negedge clk);
      memACK = 1'b0;
      // Winner withdraws and scribbles its inputs once the bus is in WAIT.
      if (g[2]) begin conREQ = 1'b0; conADDR = ~a; conDATAI = '0; end
      if (g[1]) begin ubaREQ = 1'b0; ubaADDR = ~a; ubaDATAI = '0; end
      if (g[0]) begin cpuREQ = 1'b0; cpuADDR = ~a; cpuDATAI = '0; end
      for (int k = 0; k <= delay; k++) begin
         chk($sformatf("%s.memreq_wait%0d", tag, k), {35'd0, memREQ}, 36'd1);
         if (k == 0 || k == delay) begin
            chk($sformatf("%s.addr_wait%0d", tag, k), arbADDRO, a);
            chk($sformatf("%s.data_wait%0d", tag, k), arbDATAO, d);
            chk($sformatf("%s.rd_hold%0d", tag, k), rdDATA, prev_rd);
         end
         if (ack_en && k == delay) begin
            memACK   = 1'b1;
            memDATAI = rd;
         end
         @(negedge clk);
         memACK = 1'b0;
      end
      chk({tag, ".memreq_done"}, {35'd0, memREQ}, 36'd0);
      chk({tag, ".rd_done"}, rdDATA, exp_rd);
      chk({tag, ".ack_early"}, acks(), 36'd0);
      chk({tag, ".data_done"}, arbDATAO, d);
      @(negedge clk);
      chk({tag, ".ack"}, acks(), {33'd0, g});
      chk({tag, ".gnt_clr"}, {33'd0, arbGNT}, 36'd0);
      chk({tag, ".rd_ack"}, rdDATA, exp_rd);
`ifdef ARB_TIMEOUT_EN
      chk({tag, ".nxm"}, {35'd0, nxmERR}, {35'd0, exp_nxm});
`else
      chk({tag, ".nxm"}, {35'd0, nxmERR}, 36'd0);
`endif
      prev_rd = exp_rd;
      @(negedge clk);
      chk({tag, ".ack_off"}, acks(), 36'd0);
      chk({tag, ".nxm_off"}, {35'd0, nxmERR}, 36'd0);
      chk({tag, ".turnaround"}, {35'd0, memREQ}, 36'd0);
      $display("txn %s gnt=%b delay=%0d ack=%0d rd=%o", tag, g, delay, ack_en, exp_rd);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      memACK = 1'b0; memDATAI = '0;
      cpuREQ = 1'b1; conREQ = 1'b1; ubaREQ = 1'b1;
      cpuADDR = 36'o000000000011; cpuDATAI = 36'o000000000012;
      conADDR = 36'o000000000021; conDATAI = 36'o000000000022;
      ubaADDR = 36'o000000000031; ubaDATAI = 36'o000000000032;
      repeat (3) @(negedge clk);
      chk("rst.memreq", {35'd0, memREQ}, 36'd0);
      chk("rst.acks", acks(), 36'd0);
      chk("rst.gnt", {33'd0, arbGNT}, 36'd0);
      chk("rst.rd", rdDATA, 36'd0);
      chk("rst.addr", arbADDRO, 36'd0);
      chk("rst.nxm", {35'd0, nxmERR}, 36'd0);
      rst = 1'b1;
      @(negedge clk);
      cpuREQ = 1'b0; ubaREQ = 1'b0;
      do_txn("rst_con", 3'b100, 0, 1'b1, 36'o000000000021, 36'o000000000022,
             36'o000000000777, 1'b0);
      chk("idle.gnt", {33'd0, arbGNT}, 36'd0);

      // Single CPU read, memACK on the second WAIT cycle.
      cpuREQ = 1'b1; cpuADDR = 36'o000000001000; cpuDATAI = 36'o000000000444;
      @(negedge clk);
      do_txn("cpu_rd", 3'b001, 1, 1'b1, 36'o000000001000, 36'o000000000444,
             36'o123456701234, 1'b0);

      // All three at once: CON, then UBA (write freeze), then CPU.
      conREQ = 1'b1; conADDR = 36'o000000002000; conDATAI = 36'o111111111111;
      ubaREQ = 1'b1; ubaADDR = 36'o000000003000; ubaDATAI = 36'o777777777777;
      cpuREQ = 1'b1; cpuADDR = 36'o000000004000; cpuDATAI = 36'o222222222222;
      @(negedge clk);
      do_txn("pri_con", 3'b100, 0, 1'b1, 36'o000000002000, 36'o111111111111,
             36'o000000000001, 1'b1);
      do_txn("pri_uba", 3'b010, 0, 1'b1, 36'o000000003000, 36'o777777777777,
             36'o000000000002, 1'b0);
      do_txn("pri_cpu", 3'b001, 0, 1'b1, 36'o000000004000, 36'o222222222222,
             36'o000000000003, 1'b1);
      chk("pri.idle_gnt", {33'd0, arbGNT}, 36'd0);

      // Reset in the middle of a transaction aborts it.
      cpuREQ = 1'b1; cpuADDR = 36'o000000005000; cpuDATAI = 36'o333333333333;
      @(negedge clk);
      @(negedge clk);
      cpuREQ = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst.memreq", {35'd0, memREQ}, 36'd0);
      chk("mrst.gnt", {33'd0, arbGNT}, 36'd0);
      chk("mrst.rd", rdDATA, 36'd0);
      chk("mrst.addr", arbADDRO, 36'd0);
      chk("mrst.data", arbDATAO, 36'd0);
      rst = 1'b1;
      memACK = 1'b1; memDATAI = 36'o666666666666;
      @(negedge clk);
      memACK = 1'b0;
      chk("mrst.acks", acks(), 36'd0);
      chk("mrst.ack_idle_ignored", rdDATA, 36'd0);
      @(negedge clk);
      chk("mrst.acks2", acks(), 36'd0);
      chk("mrst.memreq2", {35'd0, memREQ}, 36'd0);
      prev_rd = '0;

      // Late memACK on WAIT cycle 31 completes normally.
      cpuREQ = 1'b1; cpuADDR = 36'o000000006000; cpuDATAI = 36'o000000000055;
      @(negedge clk);
      do_txn("late_ack", 3'b001, 30, 1'b1, 36'o000000006000, 36'o000000000055,
             36'o707070707070, 1'b0);
`ifdef ARB_TIMEOUT_EN
      cpuREQ = 1'b1; cpuADDR = 36'o000000007000; cpuDATAI = 36'o000000000066;
      @(negedge clk);
      do_txn("timeout", 3'b001, 30, 1'b0, 36'o000000007000, 36'o000000000066,
             36'd0, 1'b0);
`else
      cpuREQ = 1'b1; cpuADDR = 36'o000000007000; cpuDATAI = 36'o000000000066;
      @(negedge clk);
      do_txn("no_timeout", 3'b001, 40, 1'b1, 36'o000000007000, 36'o000000000066,
             36'o010203040506, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
